// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets,
// reset constants, request encodings and small decode/merge helpers.
package clint_pkg;

  // Register offsets within the 64 KiB CLINT window (word aligned).
  localparam logic [15:0] CLINT_MSIP        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

  // mtimecmp resets to all ones so the timer interrupt stays quiet until
  // software programs a real deadline.
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Encoding of the req_mode bit.
  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_mode_e;

  // One-hot-free register select produced by the address decoder.
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_MT_LO,
    SEL_MT_HI
  } reg_sel_e;

  // Map a word address (byte address bits [15:2]) onto a register select.
  function automatic reg_sel_e decode_offset(input logic [13:0] word_addr);
    logic [15:0] offset;
    offset = {word_addr, 2'b00};
    case (offset)
      CLINT_MSIP:        return SEL_MSIP;
      CLINT_MTIMECMP_LO: return SEL_CMP_LO;
      CLINT_MTIMECMP_HI: return SEL_CMP_HI;
      CLINT_MTIME_LO:    return SEL_MT_LO;
      CLINT_MTIME_HI:    return SEL_MT_HI;
      default:           return SEL_NONE;
    endcase
  endfunction

  // Byte-lane merge of write data into an existing 32-bit register value.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// Prescaler for the mtime counter: emits a one-cycle tick every TICK_DIV
// clocks. With TICK_DIV = 1 the tick is asserted every cycle.
module clint_tick_gen #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  // Counter width; a 1-bit counter is kept even when TICK_DIV = 1.
  localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = w_last;

  // Prescaler: counts 0..TICK_DIV-1 and wraps on the tick cycle.
  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: owns mtime, mtimecmp and msip, answers a simple
// one-cycle request/response register bus and drives the core's timer and
// software interrupt lines plus the full 64-bit time value.
module clint
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        request_enable,
  input  logic        req_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        response_enable,
  output logic [31:0] resp_data,
  output logic        timer_intr,
  output logic        soft_intr,
  output logic [63:0] time_full
);

  // Architectural state.
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic        r_timer_intr;
  logic        r_resp_en;
  logic [31:0] r_resp_data;

  // Decode and next-state signals.
  logic        w_tick;
  reg_sel_e    w_sel;
  logic        w_wr;
  logic        w_rd;
  logic        w_mtime_wr;
  logic [31:0] w_rd_data;
  logic [63:0] w_mtime_nxt;
  logic [63:0] w_mtimecmp_nxt;
  logic        w_msip_nxt;

  // Address bits outside the decoded window are deliberately ignored.
  logic        w_unused_addr;
  assign w_unused_addr = ^{req_addr[31:16], req_addr[1:0]};

  clint_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rstn (rstn),
    .tick (w_tick)
  );

  assign w_sel = decode_offset(req_addr[15:2]);
  assign w_wr  = request_enable && (req_mode_e'(req_mode) == REQ_WRITE);
  assign w_rd  = request_enable && (req_mode_e'(req_mode) == REQ_READ);

  // An mtime write with no enabled byte lanes changes nothing, so it also
  // does not suppress the tick.
  assign w_mtime_wr = w_wr && (|req_wstrb) &&
                      ((w_sel == SEL_MT_LO) || (w_sel == SEL_MT_HI));

  // Read mux: current register contents, before any same-edge update.
  // NOTE: every combinational output gets a default first so no path
  // through the block leaves it unassigned and infers a latch.
  always_comb begin
    w_rd_data = '0;
    case (w_sel)
      SEL_MSIP:   w_rd_data = {31'b0, r_msip};
      SEL_CMP_LO: w_rd_data = r_mtimecmp[31:0];
      SEL_CMP_HI: w_rd_data = r_mtimecmp[63:32];
      SEL_MT_LO:  w_rd_data = r_mtime[31:0];
      SEL_MT_HI:  w_rd_data = r_mtime[63:32];
      default:    w_rd_data = '0;
    endcase
  end

  // mtime next state: a software write owns the cycle (written half takes
  // the merged data, the other half holds); otherwise a tick increments
  // the full 64-bit value with carry across halves.
  always_comb begin
    w_mtime_nxt = r_mtime;
    if (w_mtime_wr) begin
      if (w_sel == SEL_MT_LO) begin
        w_mtime_nxt[31:0] = merge_bytes(r_mtime[31:0], req_wdata, req_wstrb);
      end else begin
        w_mtime_nxt[63:32] = merge_bytes(r_mtime[63:32], req_wdata, req_wstrb);
      end
    end else if (w_tick) begin
      w_mtime_nxt = r_mtime + 64'd1;
    end
  end

  // mtimecmp and msip next state from byte-merged writes.
  always_comb begin
    w_mtimecmp_nxt = r_mtimecmp;
    w_msip_nxt     = r_msip;
    if (w_wr) begin
      case (w_sel)
        SEL_CMP_LO: w_mtimecmp_nxt[31:0]  =
                      merge_bytes(r_mtimecmp[31:0], req_wdata, req_wstrb);
        SEL_CMP_HI: w_mtimecmp_nxt[63:32] =
                      merge_bytes(r_mtimecmp[63:32], req_wdata, req_wstrb);
        SEL_MSIP:   if (req_wstrb[0]) w_msip_nxt = req_wdata[0];
        default:    ;
      endcase
    end
  end

  // Register file plus the timer compare, which looks at next-state values
  // so timer_intr lines up with the mtime/mtimecmp flops it reflects.
  // NOTE: all state here is a handful of control flops, so every one gets
  // an explicit reset value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mtime      <= '0;
      r_mtimecmp   <= MTIMECMP_RST;
      r_msip       <= 1'b0;
      r_timer_intr <= 1'b0;
    end else begin
      r_mtime      <= w_mtime_nxt;
      r_mtimecmp   <= w_mtimecmp_nxt;
      r_msip       <= w_msip_nxt;
      r_timer_intr <= (w_mtime_nxt >= w_mtimecmp_nxt);
    end
  end

  // Response stage: one pulse per accepted request, data only for reads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_resp_en   <= 1'b0;
      r_resp_data <= '0;
    end else begin
      r_resp_en   <= request_enable;
      r_resp_data <= w_rd ? w_rd_data : '0;
    end
  end

  assign response_enable = r_resp_en;
  assign resp_data       = r_resp_data;
  assign timer_intr      = r_timer_intr;
  assign soft_intr       = r_msip;
  assign time_full       = r_mtime;

endmodule

// File: tb/tb_clint.sv
// Self-checking bench for clint: one instance with TICK_DIV = 1 (bus traffic
// checked by a scoreboard) and one with TICK_DIV = 4 (prescaler timing).
module tb_clint;

  localparam logic MODE_R = 1'b0;
  localparam logic MODE_W = 1'b1;

  logic clk;
  logic rstn;

  // Instance A: TICK_DIV = 1
  logic        request_enable, req_mode;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        response_enable, timer_intr, soft_intr;
  logic [31:0] resp_data;
  logic [63:0] time_full;

  // Instance B: TICK_DIV = 4
  logic        b_request_enable, b_req_mode;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [3:0]  b_req_wstrb;
  logic        b_response_enable, b_timer_intr, b_soft_intr;
  logic [31:0] b_resp_data;
  logic [63:0] b_time_full;

  clint #(.TICK_DIV(1)) dut (
    .clk(clk), .rstn(rstn),
    .request_enable(request_enable), .req_mode(req_mode),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .response_enable(response_enable), .resp_data(resp_data),
    .timer_intr(timer_intr), .soft_intr(soft_intr), .time_full(time_full)
  );

  clint #(.TICK_DIV(4)) dut_div4 (
    .clk(clk), .rstn(rstn),
    .request_enable(b_request_enable), .req_mode(b_req_mode),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
    .response_enable(b_response_enable), .resp_data(b_resp_data),
    .timer_intr(b_timer_intr), .soft_intr(b_soft_intr), .time_full(b_time_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard of expected responses for instance A.
  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb_q[$];

  // Response monitor: a pulse exactly when an entry is due, idle otherwise.
  always @(negedge clk) begin
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      check("resp_en", {63'b0, response_enable}, 64'd1);
      check("resp_data", {32'b0, resp_data}, {32'b0, sb_q[0].data});
      void'(sb_q.pop_front());
    end else begin
      check("resp_idle_en", {63'b0, response_enable}, 64'd0);
      check("resp_idle_data", {32'b0, resp_data}, 64'd0);
    end
  end

  // Issue one request on instance A starting just after a rising edge;
  // returns just after the edge that samples it.
  task automatic bus_req(input logic mode, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic [31:0] exp_rd);
    exp_t e;
    request_enable = 1'b1;
    req_mode       = mode;
    req_addr       = addr;
    req_wdata      = wdata;
    req_wstrb      = wstrb;
    e.data = (mode == MODE_R) ? exp_rd : 32'h0;
    e.due  = cyc + 1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    request_enable = 1'b0;
  endtask

  typedef struct {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rd;
    logic        exp_soft;
  } vec_t;

  vec_t vecs[16];
  logic [63:0] exp_mt;

  initial begin
    // Table of register-access vectors applied back to back.
    vecs[0]  = '{MODE_W, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0001, 32'h0,         1'b1};
    vecs[1]  = '{MODE_R, 32'h0000_0000, 32'h0,         4'b0000, 32'h1,         1'b1};
    vecs[2]  = '{MODE_W, 32'h0000_0000, 32'h0,         4'b0000, 32'h0,         1'b1};
    vecs[3]  = '{MODE_R, 32'h0000_0000, 32'h0,         4'b0000, 32'h1,         1'b1};
    vecs[4]  = '{MODE_W, 32'h0000_0000, 32'h0,         4'b0001, 32'h0,         1'b0};
    vecs[5]  = '{MODE_R, 32'h0000_0000, 32'h0,         4'b0000, 32'h0,         1'b0};
    vecs[6]  = '{MODE_W, 32'h0000_4000, 32'hA5A5_A5A5, 4'b0101, 32'h0,         1'b0};
    vecs[7]  = '{MODE_R, 32'h0000_4000, 32'h0,         4'b0000, 32'hFFA5_FFA5, 1'b0};
    vecs[8]  = '{MODE_R, 32'h0000_4004, 32'h0,         4'b0000, 32'h0,         1'b0};
    vecs[9]  = '{MODE_W, 32'h0000_4004, 32'h1234_5678, 4'b1010, 32'h0,         1'b0};
    vecs[10] = '{MODE_R, 32'h0000_4004, 32'h0,         4'b0000, 32'h1200_5600, 1'b0};
    vecs[11] = '{MODE_R, 32'h0000_1234, 32'h0,         4'b0000, 32'h0,         1'b0};
    vecs[12] = '{MODE_W, 32'h0000_1234, 32'hFFFF_FFFF, 4'b1111, 32'h0,         1'b0};
    vecs[13] = '{MODE_R, 32'h0000_1234, 32'h0,         4'b0000, 32'h0,         1'b0};
    vecs[14] = '{MODE_R, 32'h0001_4000, 32'h0,         4'b0000, 32'hFFA5_FFA5, 1'b0};
    vecs[15] = '{MODE_R, 32'h0000_4003, 32'h0,         4'b0000, 32'hFFA5_FFA5, 1'b0};

    rstn = 1'b0;
    request_enable = 1'b0; req_mode = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    b_request_enable = 1'b0; b_req_mode = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_wstrb = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_time", time_full, 64'd0);
    check("rst_timer", {63'b0, timer_intr}, 64'd0);
    check("rst_soft", {63'b0, soft_intr}, 64'd0);
    check("rst_b_time", b_time_full, 64'd0);

    // Free run after release: A counts every edge, B every fourth edge.
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("run_a_0", time_full, 64'd0);
    check("run_b_0", b_time_full, 64'd0);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      check("run_a", time_full, 64'(i));
      check("run_b", b_time_full, 64'(i / 4));
      check("run_timer", {63'b0, timer_intr}, 64'd0);
      check("run_soft", {63'b0, soft_intr}, 64'd0);
    end

    // B: read mtime_lo in a tick cycle returns the pre-tick value.
    repeat (3) @(posedge clk);
    #1;
    b_request_enable = 1'b1; b_req_mode = MODE_R; b_req_addr = 32'h0000_BFF8;
    @(posedge clk); #1;
    b_request_enable = 1'b0;
    check("b_rd_en", {63'b0, b_response_enable}, 64'd1);
    check("b_rd_data", {32'b0, b_resp_data}, 64'd4);
    check("b_rd_time", b_time_full, 64'd5);
    @(posedge clk); #1;
    check("b_idle_en", {63'b0, b_response_enable}, 64'd0);
    check("b_idle_data", {32'b0, b_resp_data}, 64'd0);

    // Timer compare on A.
    bus_req(MODE_W, 32'h0000_BFF8, 32'h0, 4'b1111, 32'h0);
    check("mt_clear", time_full, 64'd0);
    bus_req(MODE_W, 32'h0000_4004, 32'h0, 4'b1111, 32'h0);
    bus_req(MODE_W, 32'h0000_4000, 32'd20, 4'b1111, 32'h0);
    exp_mt = 64'd2;
    check("cmp_time", time_full, exp_mt);
    check("cmp_timer", {63'b0, timer_intr}, 64'd0);
    while (exp_mt < 64'd22) begin
      @(posedge clk); #1;
      exp_mt = exp_mt + 64'd1;
      check("cmp_run_time", time_full, exp_mt);
      check("cmp_run_timer", {63'b0, timer_intr}, {63'b0, exp_mt >= 64'd20});
    end
    bus_req(MODE_W, 32'h0000_4000, 32'hFFFF_FFFF, 4'b1111, 32'h0);
    check("cmp_fall", {63'b0, timer_intr}, 64'd0);
    check("cmp_fall_time", time_full, 64'd23);

    // Wrap and write/tick collision.
    bus_req(MODE_W, 32'h0000_BFFC, 32'hFFFF_FFFF, 4'b1111, 32'h0);
    check("hi_write", time_full, 64'hFFFF_FFFF_0000_0017);
    bus_req(MODE_W, 32'h0000_BFF8, 32'hFFFF_FFFE, 4'b1111, 32'h0);
    check("lo_collide", time_full, 64'hFFFF_FFFF_FFFF_FFFE);
    check("wrap_timer_hi", {63'b0, timer_intr}, 64'd1);
    @(posedge clk); #1;
    check("wrap_max", time_full, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1;
    check("wrap_zero", time_full, 64'd0);
    check("wrap_timer_lo", {63'b0, timer_intr}, 64'd0);
    bus_req(MODE_R, 32'h0000_BFF8, 32'h0, 4'b0000, 32'h0);
    check("rd_tick_time", time_full, 64'd1);
    bus_req(MODE_R, 32'h0000_BFFC, 32'h0, 4'b0000, 32'h0);

    // Table-driven register accesses, issued back to back.
    for (int i = 0; i < 16; i++) begin
      bus_req(vecs[i].mode, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].exp_rd);
      check("vec_soft", {63'b0, soft_intr}, {63'b0, vecs[i].exp_soft});
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset while a response is pending: it must be dropped.
    begin
      exp_t e;
      request_enable = 1'b1; req_mode = MODE_R; req_addr = 32'h0000_4000;
      e.data = 32'hFFA5_FFA5;
      e.due  = cyc + 1;
      sb_q.push_back(e);
      @(posedge clk); #1;
      rstn = 1'b0;
      request_enable = 1'b0;
      sb_q.delete();
    end
    #1;
    check("mid_rst_resp", {63'b0, response_enable}, 64'd0);
    check("mid_rst_time", time_full, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus_req(MODE_R, 32'h0000_4000, 32'h0, 4'b0000, 32'hFFFF_FFFF);
    bus_req(MODE_R, 32'h0000_4004, 32'h0, 4'b0000, 32'hFFFF_FFFF);
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
